// File: rtl/vga_sync_decoder.sv
// VGA input decoder: recovers column/row from active-low syncs, verifies line and
// frame lengths, locks after consecutive good frames and emits registered pixels.
module vga_sync_decoder #(
  parameter int unsigned hpixels     = 800,
  parameter int unsigned vlines      = 521,
  parameter int unsigned hbp         = 144,
  parameter int unsigned hfp         = 784,
  parameter int unsigned vbp         = 31,
  parameter int unsigned vfp         = 511,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        dclk,
  input  logic        clr,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [3:0]  red,
  input  logic [3:0]  green,
  input  logic [3:0]  blue,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [3:0]  pix_r,
  output logic [3:0]  pix_g,
  output logic [3:0]  pix_b,
  output logic        frame_start,
  output logic        locked,
  output logic        hlen_err,
  output logic        vlen_err,
  output logic [15:0] frame_count
);

  localparam int unsigned POS_W = 10;
  localparam int unsigned X_W   = 10;
  localparam int unsigned Y_W   = 9;
  localparam int unsigned RGB_W = 12;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned FC_W  = 16;
  localparam logic [POS_W-1:0] POS_MAX = {POS_W{1'b1}};

  typedef enum logic [1:0] {
    UNSYNC = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  // Input pipeline stages A and B
  logic             hs_a_q, hs_a_d, vs_a_q, vs_a_d;
  logic             hs_b_q, hs_b_d, vs_b_q, vs_b_d;
  logic [RGB_W-1:0] rgb_a_q, rgb_a_d, rgb_b_q, rgb_b_d;

  // Position tracking and lock state
  logic [POS_W-1:0] hcol_q, hcol_d, vrow_q, vrow_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] good_cnt_q, good_cnt_d;
  logic [FC_W-1:0]  frame_count_q, frame_count_d;
  logic             herr_seen_q, herr_seen_d;

  // Output stage C
  logic             pix_valid_q, pix_valid_d;
  logic [X_W-1:0]   pix_x_q, pix_x_d;
  logic [Y_W-1:0]   pix_y_q, pix_y_d;
  logic [3:0]       pix_r_q, pix_r_d, pix_g_q, pix_g_d, pix_b_q, pix_b_d;
  logic             frame_start_q, frame_start_d;
  logic             locked_q, locked_d;
  logic             hlen_err_q, hlen_err_d, vlen_err_q, vlen_err_d;

  logic h_edge_c, v_edge_c, herr_c, verr_c, good_c, in_win_c;

  // Falling edges: stage B doubles as the previous stage A value
  always_comb begin
    h_edge_c = ~hs_a_q & hs_b_q;
    v_edge_c = ~vs_a_q & vs_b_q;
    herr_c   = h_edge_c && (hcol_q != POS_W'(hpixels - 1)) && (state_q != UNSYNC);
    verr_c   = v_edge_c && (vrow_q != POS_W'(vlines - 1)) && (state_q != UNSYNC);
    good_c   = v_edge_c && (vrow_q == POS_W'(vlines - 1)) && !herr_seen_q && !herr_c;
    in_win_c = (hcol_q >= POS_W'(hbp)) && (hcol_q < POS_W'(hfp)) &&
               (vrow_q >= POS_W'(vbp)) && (vrow_q < POS_W'(vfp));
  end

  always_comb begin
    hs_a_d  = hsync;
    vs_a_d  = vsync;
    rgb_a_d = {red, green, blue};
    hs_b_d  = hs_a_q;
    vs_b_d  = vs_a_q;
    rgb_b_d = rgb_a_q;
  end

  // hcol follows the stage B sample; vrow advances on line starts
  always_comb begin
    hcol_d = hcol_q;
    vrow_d = vrow_q;
    if (h_edge_c) begin
      hcol_d = '0;
    end else if (hcol_q != POS_MAX) begin
      hcol_d = hcol_q + POS_W'(1);
    end
    if (v_edge_c) begin
      vrow_d = '0;
    end else if (h_edge_c && (vrow_q != POS_MAX)) begin
      vrow_d = vrow_q + POS_W'(1);
    end
  end

  // Lock FSM next state and frame accounting
  always_comb begin
    state_d       = state_q;
    good_cnt_d    = good_cnt_q;
    frame_count_d = frame_count_q;
    herr_seen_d   = herr_seen_q | herr_c;
    if (v_edge_c) begin
      herr_seen_d = 1'b0;
    end
    case (state_q)
      UNSYNC: begin
        if (v_edge_c) begin
          state_d    = TRACK;
          good_cnt_d = '0;
        end
      end
      TRACK: begin
        if (herr_c || verr_c) begin
          good_cnt_d = '0;
        end else if (good_c) begin
          good_cnt_d = good_cnt_q + CNT_W'(1);
          if ((good_cnt_q + CNT_W'(1)) >= CNT_W'(LOCK_FRAMES)) begin
            state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (herr_c || verr_c) begin
          state_d    = TRACK;
          good_cnt_d = '0;
        end else if (good_c) begin
          frame_count_d = frame_count_q + FC_W'(1);
        end
      end
      default: begin
        state_d    = UNSYNC;
        good_cnt_d = '0;
      end
    endcase
  end

  // Stage C outputs from stage B and the tracked position
  always_comb begin
    locked_d      = (state_q == LOCKED);
    hlen_err_d    = herr_c;
    vlen_err_d    = verr_c;
    pix_valid_d   = (state_q == LOCKED) && in_win_c;
    pix_x_d       = X_W'(hcol_q - POS_W'(hbp));
    pix_y_d       = Y_W'(vrow_q - POS_W'(vbp));
    frame_start_d = pix_valid_d && (hcol_q == POS_W'(hbp)) && (vrow_q == POS_W'(vbp));
    pix_r_d       = 4'd0;
    pix_g_d       = 4'd0;
    pix_b_d       = 4'd0;
    if (pix_valid_d) begin
      pix_r_d = rgb_b_q[11:8];
      pix_g_d = rgb_b_q[7:4];
      pix_b_d = rgb_b_q[3:0];
    end
  end

  always_ff @(posedge dclk) begin
    if (clr) begin
      hs_a_q        <= 1'b0;
      vs_a_q        <= 1'b0;
      rgb_a_q       <= '0;
      hs_b_q        <= 1'b0;
      vs_b_q        <= 1'b0;
      rgb_b_q       <= '0;
      hcol_q        <= '0;
      vrow_q        <= '0;
      state_q       <= UNSYNC;
      good_cnt_q    <= '0;
      frame_count_q <= '0;
      herr_seen_q   <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_r_q       <= '0;
      pix_g_q       <= '0;
      pix_b_q       <= '0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      hlen_err_q    <= 1'b0;
      vlen_err_q    <= 1'b0;
    end else begin
      hs_a_q        <= hs_a_d;
      vs_a_q        <= vs_a_d;
      rgb_a_q       <= rgb_a_d;
      hs_b_q        <= hs_b_d;
      vs_b_q        <= vs_b_d;
      rgb_b_q       <= rgb_b_d;
      hcol_q        <= hcol_d;
      vrow_q        <= vrow_d;
      state_q       <= state_d;
      good_cnt_q    <= good_cnt_d;
      frame_count_q <= frame_count_d;
      herr_seen_q   <= herr_seen_d;
      pix_valid_q   <= pix_valid_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_r_q       <= pix_r_d;
      pix_g_q       <= pix_g_d;
      pix_b_q       <= pix_b_d;
      frame_start_q <= frame_start_d;
      locked_q      <= locked_d;
      hlen_err_q    <= hlen_err_d;
      vlen_err_q    <= vlen_err_d;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_r       = pix_r_q;
  assign pix_g       = pix_g_q;
  assign pix_b       = pix_b_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign hlen_err    = hlen_err_q;
  assign vlen_err    = vlen_err_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a scaled 40x20 timing generator
// (hbp 8, hfp 32, vbp 3, vfp 18) so that many frames fit in a short run.
module tb_vga_sync_decoder;

  logic        dclk = 1'b0;
  logic        clr = 1'b1;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic [3:0]  red = 4'd0, green = 4'd0, blue = 4'd0;
  logic        pix_valid, frame_start, locked, hlen_err, vlen_err;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [3:0]  pix_r, pix_g, pix_b;
  logic [15:0] frame_count;

  int checks = 0;
  int failures = 0;
  int herr_total = 0;
  int verr_total = 0;

  // Generator position of the next pixel to drive, and of the one just driven
  int hc = 0, vc = 5;
  int last_hc = -1, last_vc = -1;
  int short_vc = -1;
  bit short_frame = 1'b0;

  vga_sync_decoder #(
    .hpixels(40), .vlines(20), .hbp(8), .hfp(32), .vbp(3), .vfp(18), .LOCK_FRAMES(2)
  ) dut (
    .dclk(dclk), .clr(clr), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .frame_start(frame_start), .locked(locked),
    .hlen_err(hlen_err), .vlen_err(vlen_err), .frame_count(frame_count)
  );

  always #5 dclk = ~dclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    failures++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  // Pixel (8,3) is forced to F/0/A; elsewhere r=h, g=v, b=3h+v
  task automatic drive_pixel(input int h, input int v);
    hsync = (h >= 4);
    vsync = (v >= 2);
    if (h == 8 && v == 3) begin
      red = 4'hF; green = 4'h0; blue = 4'hA;
    end else begin
      red = 4'(h); green = 4'(v); blue = 4'(3 * h + v);
    end
  endtask

  // One dclk: sample outputs after the edge, then drive the next generator pixel
  task automatic step();
    int hlim;
    @(posedge dclk);
    #1;
    herr_total += int'(hlen_err);
    verr_total += int'(vlen_err);
    drive_pixel(hc, vc);
    last_hc = hc;
    last_vc = vc;
    hlim = (vc == short_vc) ? 39 : 40;
    hc++;
    if (hc >= hlim) begin
      hc = 0;
      if (vc == short_vc) short_vc = -1;
      vc++;
      if (vc >= (short_frame ? 19 : 20)) begin
        vc = 0;
        short_frame = 1'b0;
      end
    end
  endtask

  task automatic run_to(input int h, input int v, input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (last_hc == h && last_vc == v) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) timeout(tag);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(pix_valid), 32'd0);
    check({tag, "_x"}, 32'(pix_x), 32'd0);
    check({tag, "_y"}, 32'(pix_y), 32'd0);
    check({tag, "_rgb"}, 32'({pix_r, pix_g, pix_b}), 32'd0);
    check({tag, "_fs"}, 32'(frame_start), 32'd0);
    check({tag, "_locked"}, 32'(locked), 32'd0);
    check({tag, "_errs"}, 32'({hlen_err, vlen_err}), 32'd0);
    check({tag, "_fc"}, 32'(frame_count), 32'd0);
  endtask

  initial begin
    // Reset with the generator running mid-frame, release at hc=5, vc=5
    steps(5);
    check_all_zero("reset");
    clr = 1'b0;

    // Three v-edges to lock: unsync->track, then two good frames
    run_to(0, 0, "vedge1");
    run_to(0, 0, "vedge2");
    steps(3);
    check("lock_after_v2", 32'(locked), 32'd0);
    run_to(0, 0, "vedge3");
    steps(2);
    check("lock_v3_plus2", 32'(locked), 32'd0);
    step();
    check("lock_v3_plus3", 32'(locked), 32'd1);
    check("no_herr_at_lock", 32'(herr_total), 32'd0);
    check("no_verr_at_lock", 32'(verr_total), 32'd0);

    // First active pixel
    run_to(8, 3, "first_pix");
    steps(3);
    check("fp_valid", 32'(pix_valid), 32'd1);
    check("fp_fs", 32'(frame_start), 32'd1);
    check("fp_x", 32'(pix_x), 32'd0);
    check("fp_y", 32'(pix_y), 32'd0);
    check("fp_rgb", 32'({pix_r, pix_g, pix_b}), 32'h0F0A);
    step();
    check("fp_next_fs", 32'(frame_start), 32'd0);
    check("fp_next_x", 32'(pix_x), 32'd1);

    // Last active pixel (31,17) and first blanked column after it
    run_to(31, 17, "last_pix");
    steps(3);
    check("lp_valid", 32'(pix_valid), 32'd1);
    check("lp_x", 32'(pix_x), 32'd23);
    check("lp_y", 32'(pix_y), 32'd14);
    check("lp_rgb", 32'({pix_r, pix_g, pix_b}), 32'h0F1E);
    check("lp_fs", 32'(frame_start), 32'd0);
    step();
    check("blank_valid", 32'(pix_valid), 32'd0);
    check("blank_rgb", 32'({pix_r, pix_g, pix_b}), 32'd0);
    check("fc_before_v4", 32'(frame_count), 32'd0);

    // Good locked frame counts
    run_to(0, 0, "vedge4");
    steps(3);
    check("fc_after_v4", 32'(frame_count), 32'd1);

    // Line 5 shortened to 39 cycles
    short_vc = 5;
    run_to(0, 6, "short_line");
    steps(2);
    check("sl_herr", 32'(hlen_err), 32'd1);
    check("sl_locked_still", 32'(locked), 32'd1);
    step();
    check("sl_herr_done", 32'(hlen_err), 32'd0);
    check("sl_locked_drop", 32'(locked), 32'd0);
    run_to(0, 0, "vedge5");
    run_to(0, 0, "vedge6");
    steps(3);
    check("sl_relock_early", 32'(locked), 32'd0);
    run_to(0, 0, "vedge7");
    steps(3);
    check("sl_relock", 32'(locked), 32'd1);
    check("sl_fc", 32'(frame_count), 32'd1);
    check("sl_herr_total", 32'(herr_total), 32'd1);

    run_to(0, 0, "vedge8");
    steps(3);
    check("fc_after_v8", 32'(frame_count), 32'd2);

    // Frame of 19 lines
    short_frame = 1'b1;
    run_to(0, 0, "vedge9");
    steps(2);
    check("sf_verr", 32'(vlen_err), 32'd1);
    step();
    check("sf_verr_done", 32'(vlen_err), 32'd0);
    check("sf_locked_drop", 32'(locked), 32'd0);
    run_to(0, 0, "vedge10");
    run_to(0, 0, "vedge11");
    steps(3);
    check("sf_relock", 32'(locked), 32'd1);
    check("sf_fc", 32'(frame_count), 32'd2);
    check("sf_verr_total", 32'(verr_total), 32'd1);
    check("sf_herr_total", 32'(herr_total), 32'd1);

    // Mid-frame clear while locked, then relock from UNSYNC
    run_to(10, 10, "mid_frame");
    clr = 1'b1;
    step();
    check_all_zero("clr_pulse");
    clr = 1'b0;
    run_to(0, 0, "rvedge1");
    run_to(0, 0, "rvedge2");
    steps(3);
    check("rl_after_r2", 32'(locked), 32'd0);
    run_to(0, 0, "rvedge3");
    steps(2);
    check("rl_r3_plus2", 32'(locked), 32'd0);
    step();
    check("rl_r3_plus3", 32'(locked), 32'd1);
    check("rl_fc", 32'(frame_count), 32'd0);
    check("final_herr_total", 32'(herr_total), 32'd1);
    check("final_verr_total", 32'(verr_total), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 SHALL have parameter hpixels, default 800: expected dclk cycles per line.
REQ-002 SHALL have parameter vlines, default 521: expected lines per frame.
REQ-003 SHALL have parameters hbp 144, hfp 784, vbp 31, vfp 511: active window is columns [hbp,hfp) and rows [vbp,vfp).
REQ-004 SHALL have parameter LOCK_FRAMES, default 2: consecutive good frames needed to lock.
REQ-005 SHALL have port dclk, input, 1: pixel clock, 25 MHz; the only clock.
REQ-006 SHALL have port clr, input, 1: synchronous active-high reset.
REQ-007 SHALL have ports hsync and vsync, input, 1 each: active-low VGA syncs.
REQ-008 SHALL have ports red, green and blue, input, 4 each: VGA colour inputs.
REQ-009 SHALL have port pix_valid, output, 1: the pixel outputs hold an active-window pixel.
REQ-010 SHALL have port pix_x, output, 10: active column, 0..639.
REQ-011 SHALL have port pix_y, output, 9: active row, 0..479.
REQ-012 SHALL have ports pix_r, pix_g and pix_b, output, 4 each: captured colour.
REQ-013 SHALL have port frame_start, output, 1: one-cycle pulse at pixel (0,0).
REQ-014 SHALL have port locked, output, 1: timing verified.
REQ-015 SHALL have ports hlen_err and vlen_err, output, 1 each: one-cycle timing-error pulses.
REQ-016 SHALL have port frame_count, output, 16: count of good frames seen while locked.

Function
REQ-017 SHALL register hsync, vsync and rgb into stage A on every dclk; the stage A value is delayed once more into stage B.
REQ-018 SHALL detect an h-edge as stage A hsync = 0 while the previous stage A hsync = 1; a v-edge is the same test on vsync.
REQ-019 SHALL hold hcol (10-bit), the column of the stage B sample: 0 on the cycle after an h-edge, otherwise hcol+1, saturating at 1023.
REQ-020 SHALL hold vrow (10-bit): 0 on the cycle after a v-edge; otherwise vrow+1 on the cycle after an h-edge; otherwise held; saturating at 1023.
REQ-021 SHALL treat a v-edge and an h-edge in the same cycle (the normal case) as a v-edge for vrow.
REQ-022 SHALL pulse hlen_err for one cycle on an h-edge when hcol != hpixels-1 and the FSM is not UNSYNC.
REQ-023 SHALL pulse vlen_err for one cycle on a v-edge when vrow != vlines-1 and the FSM is not UNSYNC.
REQ-024 SHALL treat a frame as good when its closing v-edge has vrow == vlines-1 and no hlen_err fired since the previous v-edge, including in the v-edge cycle itself.
REQ-025 SHALL implement FSM UNSYNC -> TRACK on the first v-edge, with good-frame counter = 0.
REQ-026 SHALL, in TRACK, increment the counter on each good frame and enter LOCKED when the counter reaches LOCK_FRAMES.
REQ-027 SHALL move TRACK or LOCKED to TRACK with counter 0 on any hlen_err or vlen_err, and drop locked on the next cycle.
REQ-028 SHALL drive locked = 1 only in LOCKED.
REQ-029 SHALL increment frame_count, wrapping at 16 bits, on each good frame while in LOCKED; it holds across loss of lock.
REQ-030 SHALL register all pix_* outputs in stage C from stage B and hcol/vrow, giving 3 dclk of latency from input pins to outputs.
REQ-031 SHALL drive pix_valid = locked AND hbp <= hcol < hfp AND vbp <= vrow < vfp.
REQ-032 SHALL drive pix_x = hcol-hbp and pix_y = vrow-vbp, truncated to the port widths.
REQ-033 SHALL pass pix_r, pix_g and pix_b from stage B rgb when pix_valid is 1, and drive them to 0 otherwise.
REQ-034 SHALL assert frame_start only together with pix_valid, pix_x = 0 and pix_y = 0.
REQ-035 SHALL NOT produce hlen_err/vlen_err for the truncated first line or frame seen in UNSYNC.

Reset
REQ-036 SHALL, while clr = 1 at a dclk edge, clear stages A, B and C, hcol, vrow, the good-frame counter and frame_count to 0, put the FSM in UNSYNC, and drive all outputs to 0.
REQ-037 SHALL, for a clr asserted mid-frame, relock only after 1 + LOCK_FRAMES v-edges following release.
REQ-038 SHALL, on release, load the previous-sync registers with the incoming sync levels without producing edges.

Verification
REQ-039 SHALL cover: standard 800x521 timing from a 640x480 generator, clr released at hc=300 -> locked rises 3 cycles after the 3rd v-edge, with no hlen_err/vlen_err.
REQ-040 SHALL cover: generator pixel at hc=144, vc=31, rgb=F/0/A -> 3 cycles later pix_valid=1, frame_start=1, pix_x=0, pix_y=0, rgb=F/0/A.
REQ-041 SHALL cover: hc=783, vc=510 -> pix_x=639, pix_y=479, pix_valid=1; at hc=784 -> pix_valid=0 and rgb outputs 0.
REQ-042 SHALL cover: while locked, one line shortened to 799 cycles -> one hlen_err pulse, locked=0 next cycle, relock after 2 further good frames, frame_count not incremented for the bad frame.
REQ-043 SHALL cover: a frame of 520 lines -> one vlen_err pulse at its v-edge, and locked drops.
REQ-044 SHALL cover: clr pulsed mid-frame while locked -> all outputs 0 the following cycle, frame_count=0, FSM in UNSYNC.
